// File: rtl/cache_pkg.sv
// Shared cache-core types: request opcodes and tag-store sequencer states.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP     = 2'd0,
        OP_FILL       = 2'd1,
        OP_MARK_DIRTY = 2'd2,
        OP_INVALIDATE = 2'd3
    } req_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ts_state_e;

endpackage

// File: rtl/victim_select.sv
// Lowest-index invalid way picker; falls back to the replacement candidate
// when every way of the set holds a valid line.
module victim_select
    import cache_pkg::*;
#(
    parameter int unsigned  ASSOC = 8,
    localparam int unsigned WAY_W = $clog2(ASSOC)
) (
    input  logic [ASSOC-1:0] i_valid,
    input  logic [WAY_W-1:0] i_lru_way,
    output logic [WAY_W-1:0] o_victim_way
);

    // Descending scan so the lowest invalid index is the last one written
    always_comb begin
        o_victim_way = i_lru_way;
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (!i_valid[i]) o_victim_way = WAY_W'(i);
        end
    end

endmodule

// File: rtl/tag_store.sv
// Set-associative tag store: per-way tag/valid/dirty, request/response port
// with one-cycle registered responses, and a one-set-per-cycle clear sequencer.
module tag_store
    import cache_pkg::*;
#(
    parameter int unsigned  ASSOC      = 8,
    parameter int unsigned  ADDR_SIZE  = 32,
    parameter int unsigned  BLOCK_SIZE = 6,
    parameter int unsigned  INDEX_SIZE = 7,
    localparam int unsigned TAG_SIZE   = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE,
    localparam int unsigned WAY_W      = $clog2(ASSOC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WAY_W-1:0]     req_way,
    input  logic                 req_dirty,
    input  logic [WAY_W-1:0]     lru_way,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    output logic                 resp_victim_valid,
    output logic                 resp_dirty,
    output logic [ADDR_SIZE-1:0] resp_wb_addr,
    output logic                 busy
);

    localparam int unsigned          SETS     = 2 ** INDEX_SIZE;
    localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(SETS - 1);

    ts_state_e               r_state;
    ts_state_e               w_state_nxt;
    logic [INDEX_SIZE-1:0]   r_clr_idx;

    logic [ASSOC-1:0]        r_valid [SETS];
    logic [ASSOC-1:0]        r_dirty [SETS];
    logic [TAG_SIZE-1:0]     r_tag   [SETS][ASSOC];

    req_op_e                 w_op;
    logic                    w_accept;
    logic [INDEX_SIZE-1:0]   w_idx;
    logic [TAG_SIZE-1:0]     w_tag;
    logic [ASSOC-1:0]        w_set_valid;
    logic [ASSOC-1:0]        w_set_dirty;
    logic [ASSOC-1:0]        w_hit_vec;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [WAY_W-1:0]        w_vic_way;
    logic                    w_unused_offset;

    logic                    w_resp_valid, r_resp_valid;
    logic                    w_resp_hit, r_resp_hit;
    logic [WAY_W-1:0]        w_resp_way, r_resp_way;
    logic                    w_resp_vv, r_resp_vv;
    logic                    w_resp_dirty, r_resp_dirty;
    logic [ADDR_SIZE-1:0]    w_resp_wb, r_resp_wb;

    assign w_op            = req_op_e'(req_op);
    assign w_accept        = req_valid && (r_state == ST_READY);
    assign w_idx           = req_addr[BLOCK_SIZE +: INDEX_SIZE];
    assign w_tag           = req_addr[ADDR_SIZE-1 -: TAG_SIZE];
    assign w_set_valid     = r_valid[w_idx];
    assign w_set_dirty     = r_dirty[w_idx];
    assign w_unused_offset = ^req_addr[BLOCK_SIZE-1:0];

    // State register: reset always restarts the clear sequence
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Next state: leave CLEAR once the last set has been wiped
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && r_clr_idx == LAST_SET) w_state_nxt = ST_READY;
    end

    // State-decoded handshake outputs
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        if (r_state == ST_READY) req_ready = 1'b1;
        else                     busy      = 1'b1;
    end

    // Clear index walks every set once per clear sequence
    always_ff @(posedge clk) begin
        if (rst)                       r_clr_idx <= '0;
        else if (r_state == ST_CLEAR)  r_clr_idx <= r_clr_idx + INDEX_SIZE'(1);
    end

    // Valid/dirty array: clear sequencer wipes a set, accepted writes update one way
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_valid[r_clr_idx] <= '0;
                r_dirty[r_clr_idx] <= '0;
            end else if (w_accept) begin
                case (w_op)
                    OP_FILL: begin
                        r_valid[w_idx][req_way] <= 1'b1;
                        r_dirty[w_idx][req_way] <= req_dirty;
                    end
                    OP_MARK_DIRTY: begin
                        if (w_set_valid[req_way]) r_dirty[w_idx][req_way] <= 1'b1;
                    end
                    OP_INVALIDATE: begin
                        r_valid[w_idx][req_way] <= 1'b0;
                        r_dirty[w_idx][req_way] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tag array: written only by FILL, never cleared
    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_op == OP_FILL) r_tag[w_idx][req_way] <= w_tag;
    end

    // Tag compare across the addressed set; lowest matching way wins
    always_comb begin
        w_hit_way = '0;
        for (int i = 0; i < ASSOC; i++) begin
            w_hit_vec[i] = w_set_valid[i] && (r_tag[w_idx][i] == w_tag);
        end
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
        end
        w_hit = |w_hit_vec;
    end

    victim_select #(
        .ASSOC        (ASSOC)
    ) u_victim_select (
        .i_valid      (w_set_valid),
        .i_lru_way    (lru_way),
        .o_victim_way (w_vic_way)
    );

    // Response payload from pre-edge array state
    always_comb begin
        w_resp_valid = 1'b0;
        w_resp_hit   = 1'b0;
        w_resp_way   = '0;
        w_resp_vv    = 1'b0;
        w_resp_dirty = 1'b0;
        w_resp_wb    = '0;
        if (w_accept) begin
            w_resp_valid = 1'b1;
            if (w_op == OP_LOOKUP) begin
                if (w_hit) begin
                    w_resp_hit = 1'b1;
                    w_resp_way = w_hit_way;
                end else begin
                    w_resp_way   = w_vic_way;
                    w_resp_vv    = w_set_valid[w_vic_way];
                    w_resp_dirty = w_set_valid[w_vic_way] && w_set_dirty[w_vic_way];
                    if (w_resp_dirty)
                        w_resp_wb = {r_tag[w_idx][w_vic_way], w_idx, {BLOCK_SIZE{1'b0}}};
                end
            end else begin
                w_resp_way = req_way;
            end
        end
    end

    // Response register; reset drops any pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_resp_vv    <= 1'b0;
            r_resp_dirty <= 1'b0;
            r_resp_wb    <= '0;
        end else begin
            r_resp_valid <= w_resp_valid;
            r_resp_hit   <= w_resp_hit;
            r_resp_way   <= w_resp_way;
            r_resp_vv    <= w_resp_vv;
            r_resp_dirty <= w_resp_dirty;
            r_resp_wb    <= w_resp_wb;
        end
    end

    assign resp_valid        = r_resp_valid;
    assign resp_hit          = r_resp_hit;
    assign resp_way          = r_resp_way;
    assign resp_victim_valid = r_resp_vv;
    assign resp_dirty        = r_resp_dirty;
    assign resp_wb_addr      = r_resp_wb;

endmodule

// File: tb/tb_tag_store.sv
// Bench for tag_store: spec-level model plus directed scenarios.
module tb_tag_store;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_way = 3'd0;
    logic        req_dirty = 1'b0;
    logic [2:0]  lru_way = 3'd0;
    logic        resp_valid;
    logic        resp_hit;
    logic [2:0]  resp_way;
    logic        resp_victim_valid;
    logic        resp_dirty;
    logic [31:0] resp_wb_addr;
    logic        busy;

    tag_store dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_way           (req_way),
        .req_dirty         (req_dirty),
        .lru_way           (lru_way),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_victim_valid (resp_victim_valid),
        .resp_dirty        (resp_dirty),
        .resp_wb_addr      (resp_wb_addr),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Spec-level model
    bit          m_valid [128][8];
    bit          m_dirty [128][8];
    logic [18:0] m_tag   [128][8];
    int          m_cnt;
    bit          model_live = 1'b0;
    bit          e_ready = 1'b0;
    bit          e_rv, e_hit, e_vv, e_dirty;
    logic [2:0]  e_way;
    logic [31:0] e_wb;
    logic [6:0]  m_idx;
    logic [18:0] m_tg;
    int          m_hw, m_v;

    always @(posedge clk) begin
        model_live = 1'b1;
        e_rv = 0; e_hit = 0; e_way = 0; e_vv = 0; e_dirty = 0; e_wb = 0;
        if (rst) begin
            m_cnt   = 0;
            e_ready = 0;
            for (int s = 0; s < 128; s++)
                for (int w = 0; w < 8; w++) begin
                    m_valid[s][w] = 0;
                    m_dirty[s][w] = 0;
                end
        end else begin
            if (e_ready && req_valid) begin
                m_idx = req_addr[12:6];
                m_tg  = req_addr[31:13];
                e_rv  = 1;
                e_way = req_way;
                case (req_op)
                    2'd0: begin
                        m_hw = -1;
                        for (int w = 0; w < 8; w++)
                            if (m_hw < 0 && m_valid[m_idx][w] && m_tag[m_idx][w] == m_tg) m_hw = w;
                        if (m_hw >= 0) begin
                            e_hit = 1;
                            e_way = 3'(m_hw);
                        end else begin
                            m_v = -1;
                            for (int w = 0; w < 8; w++)
                                if (m_v < 0 && !m_valid[m_idx][w]) m_v = w;
                            if (m_v < 0) m_v = int'(lru_way);
                            e_way   = 3'(m_v);
                            e_vv    = m_valid[m_idx][m_v];
                            e_dirty = m_valid[m_idx][m_v] && m_dirty[m_idx][m_v];
                            if (e_dirty) e_wb = {m_tag[m_idx][m_v], m_idx, 6'd0};
                        end
                    end
                    2'd1: begin
                        m_tag[m_idx][req_way]   = m_tg;
                        m_valid[m_idx][req_way] = 1;
                        m_dirty[m_idx][req_way] = req_dirty;
                    end
                    2'd2: if (m_valid[m_idx][req_way]) m_dirty[m_idx][req_way] = 1;
                    default: begin
                        m_valid[m_idx][req_way] = 0;
                        m_dirty[m_idx][req_way] = 0;
                    end
                endcase
            end
            if (!e_ready) begin
                m_cnt++;
                if (m_cnt == 128) e_ready = 1;
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(!e_ready));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rv) begin
                chk("resp_hit", 32'(resp_hit), 32'(e_hit));
                chk("resp_way", 32'(resp_way), 32'(e_way));
                if (!e_hit) begin
                    chk("resp_victim_valid", 32'(resp_victim_valid), 32'(e_vv));
                    chk("resp_dirty", 32'(resp_dirty), 32'(e_dirty));
                    if (e_dirty) chk("resp_wb_addr", resp_wb_addr, e_wb);
                end
            end
            if (!e_ready) begin
                chk("clear_hit", 32'(resp_hit), 32'd0);
                chk("clear_way", 32'(resp_way), 32'd0);
                chk("clear_vv", 32'(resp_victim_valid), 32'd0);
                chk("clear_dirty", 32'(resp_dirty), 32'd0);
                chk("clear_wb", resp_wb_addr, 32'd0);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [18:0] t, input logic [6:0] s);
        return {t, s, 6'd0};
    endfunction

    // Present one request for one edge; returns #1 after that edge
    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [2:0] w,
                       input logic d, input logic [2:0] l);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_way   = w;
        req_dirty = d;
        lru_way   = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 300 && !req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 || k == 127 || k == 128) begin
                chk("clear_len_busy", 32'(busy), 32'(k < 128));
                chk("clear_len_ready", 32'(req_ready), 32'(k == 128));
            end
        end

        // Fill then lookup same address
        req(2'd1, 32'h1234_5640, 3'd3, 1'b0, 3'd0);
        chk("fill_ack_valid", 32'(resp_valid), 32'd1);
        chk("fill_ack_way", 32'(resp_way), 32'd3);
        req(2'd0, 32'h1234_5640, 3'd0, 1'b0, 3'd0);
        chk("lkp_hit", 32'(resp_hit), 32'd1);
        chk("lkp_hit_way", 32'(resp_way), 32'd3);
        @(posedge clk); #1;
        chk("pulse_end", 32'(resp_valid), 32'd0);

        // Full set 5, dirty ways 2 and 6, victim from lru_way
        for (int w = 0; w < 8; w++)
            req(2'd1, mk(19'(32'h100 + w), 7'd5), 3'(w), (w == 2 || w == 6), 3'd0);
        req(2'd0, mk(19'h7ABC, 7'd5), 3'd0, 1'b0, 3'd6);
        chk("full_hit", 32'(resp_hit), 32'd0);
        chk("full_way", 32'(resp_way), 32'd6);
        chk("full_vv", 32'(resp_victim_valid), 32'd1);
        chk("full_dirty", 32'(resp_dirty), 32'd1);
        chk("full_wb", resp_wb_addr, 32'h0020_C140);

        // Invalidate way 4: lowest invalid way overrides lru_way
        req(2'd3, mk(19'h0, 7'd5), 3'd4, 1'b0, 3'd0);
        chk("inv_ack_way", 32'(resp_way), 32'd4);
        req(2'd0, mk(19'h7ABC, 7'd5), 3'd0, 1'b0, 3'd6);
        chk("inv_way", 32'(resp_way), 32'd4);
        chk("inv_vv", 32'(resp_victim_valid), 32'd0);
        chk("inv_dirty", 32'(resp_dirty), 32'd0);

        // MARK_DIRTY on an invalid way has no effect
        req(2'd2, mk(19'h0, 7'd5), 3'd4, 1'b0, 3'd0);
        req(2'd1, mk(19'h200, 7'd5), 3'd4, 1'b0, 3'd0);
        req(2'd0, mk(19'h7ABC, 7'd5), 3'd0, 1'b0, 3'd4);
        chk("md_way", 32'(resp_way), 32'd4);
        chk("md_vv", 32'(resp_victim_valid), 32'd1);
        chk("md_dirty", 32'(resp_dirty), 32'd0);
        req(2'd0, mk(19'h7ABC, 7'd5), 3'd0, 1'b0, 3'd2);
        chk("wb2_dirty", 32'(resp_dirty), 32'd1);
        chk("wb2_addr", resp_wb_addr, 32'h0020_4140);

        // Back-to-back fill then lookup to the same set
        req(2'd1, mk(19'h333, 7'd9), 3'd1, 1'b1, 3'd0);
        req(2'd0, mk(19'h333, 7'd9), 3'd0, 1'b0, 3'd0);
        chk("b2b_hit", 32'(resp_hit), 32'd1);
        chk("b2b_way", 32'(resp_way), 32'd1);

        // Reset at acceptance edge drops the response and restarts the clear
        req_valid = 1'b1; req_op = 2'd0; req_addr = mk(19'h333, 7'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_drop_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        req(2'd1, mk(19'h444, 7'd9), 3'd2, 1'b0, 3'd0);
        chk("clear_ignored", 32'(resp_valid), 32'd0);
        wait_ready();
        req(2'd0, mk(19'h333, 7'd9), 3'd0, 1'b0, 3'd5);
        chk("post_rst_hit", 32'(resp_hit), 32'd0);
        chk("post_rst_way", 32'(resp_way), 32'd0);
        chk("post_rst_vv", 32'(resp_victim_valid), 32'd0);
        req(2'd0, mk(19'h444, 7'd9), 3'd0, 1'b0, 3'd5);
        chk("ignored_fill_miss", 32'(resp_hit), 32'd0);
        req(2'd0, mk(19'h100, 7'd5), 3'd0, 1'b0, 3'd5);
        chk("set5_cleared", 32'(resp_hit), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tag_store.md
# tag_store

Next-generation set-associative tag store for the cache core: tag, valid and dirty state per way, with a request/response interface and a hardware clear sequencer. It replaces the flat reset copy with a one-set-per-cycle clear. Each lookup returns the hit way and the victim choice, with the victim's dirty status and write-back address, one cycle after acceptance. It sits between the cache controller (which issues requests) and the replacement-policy block (which supplies `lru_way`).

## Interface
- `ASSOC`, 8: ways per set; power of two, ≥2.
- `ADDR_SIZE`, 32: address width.
- `BLOCK_SIZE`, 6: block-offset bits.
- `INDEX_SIZE`, 7: index bits; SETS = 2**INDEX_SIZE.
- `TAG_SIZE`, ADDR_SIZE-BLOCK_SIZE-INDEX_SIZE: derived, not overridden.
- `WAY_W`, $clog2(ASSOC): derived.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_op` in 2: 0 LOOKUP, 1 FILL, 2 MARK_DIRTY, 3 INVALIDATE.
- `req_addr` in ADDR_SIZE: tag and index source; offset ignored.
- `req_way` in WAY_W: target way for FILL, MARK_DIRTY and INVALIDATE.
- `req_dirty` in 1: dirty value written on FILL.
- `lru_way` in WAY_W: replacement candidate, sampled at acceptance.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_hit` out 1: LOOKUP hit.
- `resp_way` out WAY_W: hit way on a hit, victim way on a miss.
- `resp_victim_valid` out 1: victim holds a valid line (miss only).
- `resp_dirty` out 1: victim valid and dirty, so a write-back is required (miss only).
- `resp_wb_addr` out ADDR_SIZE: {victim tag, index, BLOCK_SIZE'0}; meaningful when `resp_dirty`.
- `busy` out 1: clear sequence in progress.

## Operation
- States: CLEAR and READY.
- `rst` forces CLEAR with clear index 0.
- In CLEAR, each cycle clears valid and dirty for all ways of the current set, then increments the index. After the SETS-1 set the FSM moves to READY.
- Tags are not cleared.
- `req_ready` = (state == READY). `busy` = (state == CLEAR).
- LOOKUP hit: a way matches when valid and its tag equals `req_addr` tag. If several ways match (illegal), the lowest index wins.
- LOOKUP miss: victim = lowest-index invalid way; if all ways are valid, victim = `lru_way`. `resp_victim_valid`, `resp_dirty` and `resp_wb_addr` are taken from the victim's state.
- FILL: writes tag, sets valid = 1 and dirty = `req_dirty` for `req_way`.
- MARK_DIRTY: sets dirty = 1 on `req_way` only if that way is valid; otherwise no change.
- INVALIDATE: clears valid and dirty on `req_way`.
- FILL, MARK_DIRTY and INVALIDATE are acknowledged with `resp_valid` = 1 and `resp_hit` = 0. `resp_way` echoes `req_way`; the other response fields are 0.
- No response backpressure: the controller must sink each response in its pulse cycle.

## Timing
- Reset values: `req_ready` 0, `busy` 1, `resp_valid` 0, `resp_hit` 0, `resp_way` 0, `resp_victim_valid` 0, `resp_dirty` 0, `resp_wb_addr` 0.
- Clear takes exactly SETS cycles after the `rst` deassert edge; `req_ready` rises on cycle SETS (128 with defaults).
- Latency: a request accepted on edge N produces `resp_valid` during cycle N+1. All response fields are registered.
- Throughput: one request per cycle, back-to-back.
- Writes commit at the acceptance edge. LOOKUP evaluates the array state before that edge.
- A lookup accepted one cycle after a write to the same set sees the write; no bypass is needed.
- `rst` asserted mid-operation: the pending response is dropped (`resp_valid` 0 next cycle) and the clear restarts from index 0.
- `rst` asserted during CLEAR restarts the count.
- Requests presented during CLEAR are ignored and no state changes.
- `lru_way` is ignored whenever an invalid way exists.

## Structure
- The shared package `cache_pkg` holds the `req_op` enum (LOOKUP/FILL/MARK_DIRTY/INVALIDATE) and the CLEAR/READY state enum.
- Sub-module `victim_select`: combinational lowest-index priority picker over the valid vector, with `lru_way` fallback; reused by later replacement logic.
- Valid and dirty are flop arrays (SETS×ASSOC). Tags are an array indexed [set][way].

## Test plan
- Reset then idle: `busy` 1 for exactly 128 cycles, `req_ready` rises on cycle 128, all outputs 0 throughout.
- FILL addr 0x1234_5640 way 3 dirty 0, then LOOKUP same addr -> `resp_hit` 1, `resp_way` 3, one cycle after acceptance.
- Fill all 8 ways of set 5 (ways 2 and 6 with dirty 1), `lru_way` = 6, LOOKUP new tag in set 5 -> `resp_hit` 0, way 6, `resp_victim_valid` 1, `resp_dirty` 1, `resp_wb_addr` = {way-6 tag, 7'd5, 6'd0}.
- INVALIDATE way 4 of that set, then the same LOOKUP with `lru_way` = 6 -> victim way 4, `resp_victim_valid` 0, `resp_dirty` 0.
- MARK_DIRTY on an invalid way followed by FILL of that way with `req_dirty` 0 -> a later miss selecting that way reports `resp_dirty` 0.
- Back-to-back FILL then LOOKUP to the same set -> hit on the second. `rst` pulsed while a response is pending -> no `resp_valid`, clear restarts, and the previously filled tag misses afterwards.
